// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package disp_pkg;

  // Arbiter FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } disp_state_t;

  // Number of requesters sharing the display.
  localparam int N_REQ = 3;

  // Value driven to the display when nobody owns it.
  localparam logic [31:0] DEF_IDLE_VALUE = 32'h0000_0000;

endpackage

// File: rtl/disp_pick.sv
// Masked priority encoder: picks the lowest-index request not blocked by mask.
module disp_pick
  import disp_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  output logic             valid,
  output logic [1:0]       idx
);

  logic [N_REQ-1:0] eff;

  // Lowest set bit of the masked request vector wins.
  always_comb begin
    eff   = req & ~mask;
    valid = |eff;
    idx   = 2'd0;
    if (eff[0])      idx = 2'd0;
    else if (eff[1]) idx = 2'd1;
    else if (eff[2]) idx = 2'd2;
  end

endmodule

// File: rtl/disp_arbiter.sv
// Grants the shared 8-digit display to one of three requesters for a
// guaranteed minimum hold time and registers the owner's value.
//
// Request/grant protocol: req[i] is a level that the requester holds until
// grant[i] is seen; the owner keeps grant for at least HOLD_CYCLES cycles,
// and lost[i] pulses for one cycle on the edge that takes ownership away.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int          HOLD_CYCLES = 100_000_000,
  parameter int          CNT_W       = 27,
  parameter logic [31:0] IDLE_VALUE  = DEF_IDLE_VALUE
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] req,
  input  logic [31:0]      val0,
  input  logic [31:0]      val1,
  input  logic [31:0]      val2,
  output logic [N_REQ-1:0] grant,
  output logic [31:0]      disp_value,
  output logic             busy,
  output logic [N_REQ-1:0] lost,
  output logic             dbg_state
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  disp_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       owner, owner_n;
  logic [N_REQ-1:0] grant_n, lost_n, pick_mask;
  logic [31:0]      disp_n, pick_val, own_val;
  logic             pick_valid, own_req;
  logic [1:0]       pick_idx;

  assign dbg_state = state;

  // In IDLE every request competes; in SHOW the current owner is masked out
  // so a pick means someone else is waiting.
  assign pick_mask = (state == SHOW) ? grant : '0;

  disp_pick u_pick (
    .req   (req),
    .mask  (pick_mask),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Value and request muxes for the picked candidate and the current owner.
  always_comb begin
    pick_val = val0;
    own_val  = val0;
    own_req  = req[0];
    case (pick_idx)
      2'd1:    pick_val = val1;
      2'd2:    pick_val = val2;
      default: pick_val = val0;
    endcase
    case (owner)
      2'd1:    begin own_val = val1; own_req = req[1]; end
      2'd2:    begin own_val = val2; own_req = req[2]; end
      default: begin own_val = val0; own_req = req[0]; end
    endcase
  end

  // Next-state logic: grant, hold countdown, and the decision edge at cnt == 0.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    owner_n = owner;
    grant_n = grant;
    disp_n  = disp_value;
    lost_n  = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = SHOW;
          owner_n = pick_idx;
          grant_n = 3'b001 << pick_idx;
          cnt_n   = HOLD_LOAD;
          disp_n  = pick_val;
        end else begin
          grant_n = '0;
          disp_n  = IDLE_VALUE;
        end
      end
      SHOW: begin
        if (cnt != '0) begin
          // Hold window: no preemption, value follows owner while it requests.
          cnt_n = cnt - CNT_W'(1);
          if (own_req) disp_n = own_val;
        end else if (pick_valid) begin
          // Hand over to the lowest-index waiting requester.
          owner_n = pick_idx;
          grant_n = 3'b001 << pick_idx;
          cnt_n   = HOLD_LOAD;
          disp_n  = pick_val;
          lost_n  = grant;
        end else if (own_req) begin
          // Nobody else waiting: renew the current owner.
          cnt_n  = HOLD_LOAD;
          disp_n = own_val;
        end else begin
          // Owner gone and nobody waiting: release the display.
          state_n = IDLE;
          grant_n = '0;
          disp_n  = IDLE_VALUE;
          lost_n  = grant;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        disp_n  = IDLE_VALUE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 2'd0;
      grant      <= '0;
      disp_value <= IDLE_VALUE;
      busy       <= 1'b0;
      lost       <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      owner      <= owner_n;
      grant      <= grant_n;
      disp_value <= disp_n;
      busy       <= (state_n == SHOW);
      lost       <= lost_n;
    end
  end

endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Shares the single 8-digit seven-segment display between three game requesters (e.g. 0 = miss/alert banner, 1 = score, 2 = timer). Each requester presents a 32-bit hex-nibble value. The block grants display ownership for a guaranteed minimum hold time and drives the registered `disp_value` bus into the display multiplexer. It sits between the game-logic blocks and the multiplexer; the multiplexer itself is unchanged.

## Interface
- `HOLD_CYCLES`, 100_000_000: minimum ownership time in CLK cycles (1 s at 100 MHz); legal range ≥ 1.
- `CNT_W`, 27: hold-counter width; must satisfy 2^CNT_W > HOLD_CYCLES-1.
- `IDLE_VALUE`, 32'h0000_0000: value shown when no requester owns the display.

- `CLK` in 1: system clock, all logic on the rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `req` in 3: `req[i]` high = requester i wants the display; level, not pulse.
- `val0`, `val1`, `val2` in 32 each: requester values, 8 nibbles, nibble 0 = rightmost digit.
- `grant` out 3: one-hot owner, or 0 when idle.
- `disp_value` out 32: to the multiplexer `disp_value` input.
- `busy` out 1: high when any requester owns the display.
- `lost` out 3: one-cycle pulse on `lost[i]` when requester i loses ownership.

## Operation
- States: IDLE, SHOW. Reset values: state IDLE, `grant`=0, `disp_value`=IDLE_VALUE, `busy`=0, `lost`=0, hold counter 0, owner index 0.
- **IDLE**
  - If `req`≠0: grant the lowest-index requester with req high, load the counter with HOLD_CYCLES-1, load `disp_value` from that requester's value, and go to SHOW.
  - Otherwise `disp_value` holds IDLE_VALUE.
- **SHOW, counter ≠ 0**
  - Counter decrements by 1.
  - No preemption, regardless of other requests.
  - While the owner's req is high, `disp_value` tracks the owner's `valN`, registered with one cycle of delay.
  - When the owner's req is low, `disp_value` freezes at its last value.
- **SHOW, counter = 0** (decision edge)
  - Mask = req with the owner bit cleared.
  - If mask≠0: switch to the lowest-index set bit of mask. Reload the counter, load its value, and pulse `lost[owner]`.
  - Else if the owner's req is high: renew, reload the counter, no `lost` pulse.
  - Else: release. Go to IDLE, `grant`=0, `disp_value`=IDLE_VALUE, pulse `lost[owner]`.
- Switching is back-to-back: a new owner takes over on the decision edge with no idle cycle between owners.
- `busy` = (state == SHOW), registered.
- Simultaneous requests in IDLE: the lowest index wins.
- A requester whose req rises and falls entirely within another owner's hold window is never served. Requesters must hold req until granted.
- HOLD_CYCLES = 1: the counter is always 0, so every SHOW cycle is a decision edge.
- Reset asserted mid-operation: all registers take their reset values on the next CLK edge. No `lost` pulse is generated.

## Timing
- Request to grant: `req` sampled at edge k; `grant` and `disp_value` updated at edge k, visible after edge k (1-cycle latency from IDLE).
- Ownership lasts exactly HOLD_CYCLES cycles per grant or renewal, measured from the grant edge to the decision edge.
- `lost[i]` is high for the single cycle following the decision edge; `grant` changes on that same edge.
- Value tracking: `valN` change at edge k appears on `disp_value` after edge k.

## Structure
- Package `disp_pkg`: state enum (IDLE, SHOW), requester count constant N_REQ = 3, default IDLE_VALUE.
- Sub-module `disp_pick`: combinational masked priority encoder. Inputs are a 3-bit request and a 3-bit mask; outputs are a valid flag and a 2-bit index. It is used for both the IDLE grant (mask = 0) and the SHOW decision (mask = owner one-hot).
- Top module `disp_arbiter`: FSM, hold counter, owner register, value mux/register.

## Test plan
All scenarios use HOLD_CYCLES = 4 and CNT_W = 3.
- **Reset and idle:** RST_N low 2 cycles, then `req`=0 → `grant`=000, `busy`=0, `disp_value`=0, `lost`=000 throughout.
- **Single requester:** `req`=010, `val1`=32'h0000_1234 at edge 0 → after edge 0, `grant`=010 and `disp_value`=32'h0000_1234. Drop req at edge 1 → `grant` stays 010 through edge 3. Release at edge 4 → `grant`=000, `disp_value`=0, `lost`=010 for 1 cycle.
- **Priority and rotation:** `req`=111 held → owner sequence 0,1,0,1,… with ownership changing every 4 cycles. `lost` pulses on each change. Requester 2 is never granted.
- **No early preemption:** owner 2 granted at edge 0; `req[0]` rises at edge 1 → `grant`=100 until edge 4, then `grant`=001 and `lost`=100.
- **Renewal and live value:** only `req[1]` high for 12 cycles, with `val1` incremented each cycle → `grant`=010 throughout, no `lost` pulse, `disp_value` equals `val1` delayed by one cycle.
- **Reset mid-SHOW:** RST_N low while owner 1 holds with counter = 2 → next edge `grant`=000, `disp_value`=0, `lost`=000.
